// File: rtl/wave_read_arbiter.sv
// Shares the wave BRAM read port among oscillators, visualiser and debugger; round-robin oscillators, then viz, then debug.
// Latency: request in cycle c -> bram_en_out in c+1 -> data/valid in c+2+BRAM_LATENCY.
// Backpressure: bram_busy_in blocks new grants and holds pending requests; reads already in flight always return.
// Optional feature macro: STARVATION_GUARD_EN (viz/debug starvation counters that can pre-empt the oscillators).
module wave_read_arbiter #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 18,
  parameter int BRAM_LATENCY    = 2,
  parameter int STARVE_LIMIT    = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [WW_WIDTH-1:0]                  wave_width_in,
  input  logic                                 bram_busy_in,
  input  logic [NUM_OSCILLATORS-1:0]           osc_req_in,
  input  logic [NUM_OSCILLATORS*WW_WIDTH-1:0]  osc_index_in,
  output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_out,
  output logic [NUM_OSCILLATORS-1:0]           osc_valid_out,
  input  logic                                 viz_req_in,
  input  logic [WW_WIDTH-1:0]                  viz_index_in,
  output logic [SAMPLE_WIDTH-1:0]              viz_data_out,
  output logic                                 viz_valid_out,
  input  logic                                 debug_req_in,
  input  logic [WW_WIDTH-1:0]                  debug_index_in,
  output logic [SAMPLE_WIDTH-1:0]              debug_data_out,
  output logic                                 debug_valid_out,
  output logic [WW_WIDTH-1:0]                  bram_addr_out,
  output logic                                 bram_en_out,
  input  logic [SAMPLE_WIDTH-1:0]              bram_data_in
);

  // Requester ids: oscillators 0..N-1, then viz, then debug.
  localparam int NUM_REQ   = NUM_OSCILLATORS + 2;
  localparam int VIZ_ID    = NUM_OSCILLATORS;
  localparam int DBG_ID    = NUM_OSCILLATORS + 1;
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int PTR_W     = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam int TAG_DEPTH = BRAM_LATENCY + 1;

  logic [NUM_REQ-1:0]  req_all;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  active;
  logic [WW_WIDTH-1:0] req_index  [NUM_REQ];
  logic [WW_WIDTH-1:0] held_index [NUM_REQ];
  logic [WW_WIDTH-1:0] eff_index  [NUM_REQ];

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;
  logic                gnt_vld;
  logic                gnt_osc;
  logic [ID_W-1:0]     gnt_id;
  logic [WW_WIDTH-1:0] gnt_addr;
  int                  cand;

  logic [TAG_DEPTH-1:0] tag_vld;
  logic [ID_W-1:0]      tag_id [TAG_DEPTH];

  logic viz_starved;
  logic dbg_starved;

  // Flatten all requesters into one id space; an incoming index overrides the held one.
  always_comb begin
    req_all = {debug_req_in, viz_req_in, osc_req_in};
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      req_index[i] = osc_index_in[i*WW_WIDTH +: WW_WIDTH];
    end
    req_index[VIZ_ID] = viz_index_in;
    req_index[DBG_ID] = debug_index_in;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_index[i] = req_all[i] ? req_index[i] : held_index[i];
    end
    active = pending | req_all;
  end

  // Pick at most one requester: starved viz/debug, then oscillators round-robin, then viz, then debug.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_osc = 1'b0;
    gnt_id  = '0;
    rr_next = rr_ptr;
    cand    = 0;
    if (!bram_busy_in) begin
      if (viz_starved && active[VIZ_ID]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(VIZ_ID);
      end else if (dbg_starved && active[DBG_ID]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(DBG_ID);
      end
      for (int k = 0; k < NUM_OSCILLATORS; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_OSCILLATORS) cand = cand - NUM_OSCILLATORS;
        if (!gnt_vld && active[cand]) begin
          gnt_vld = 1'b1;
          gnt_osc = 1'b1;
          gnt_id  = ID_W'(cand);
          rr_next = (cand == NUM_OSCILLATORS - 1) ? '0 : PTR_W'(cand + 1);
        end
      end
      if (!gnt_vld && active[VIZ_ID]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(VIZ_ID);
      end else if (!gnt_vld && active[DBG_ID]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(DBG_ID);
      end
    end
    // Out-of-range (including an empty wave) reads sample 0.
    gnt_addr = (eff_index[gnt_id] >= wave_width_in) ? '0 : eff_index[gnt_id];
  end

  // Capture requests, issue the granted read and advance the round-robin pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending       <= '0;
      rr_ptr        <= '0;
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      for (int i = 0; i < NUM_REQ; i++) held_index[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // A request that was already waiting and re-asserts on its grant cycle earns one more read;
        // a fresh request granted on its own cycle is consumed by that grant.
        if (gnt_vld && gnt_id == ID_W'(i)) pending[i] <= pending[i] & req_all[i];
        else                               pending[i] <= pending[i] | req_all[i];
        if (req_all[i]) held_index[i] <= req_index[i];
      end
      bram_en_out <= gnt_vld;
      if (gnt_vld) bram_addr_out <= gnt_addr;
      if (gnt_osc) rr_ptr <= rr_next;
    end
  end

  // Carry requester tags alongside the BRAM pipeline and steer returning data to its owner.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tag_vld         <= '0;
      osc_data_out    <= '0;
      osc_valid_out   <= '0;
      viz_data_out    <= '0;
      viz_valid_out   <= 1'b0;
      debug_data_out  <= '0;
      debug_valid_out <= 1'b0;
      for (int k = 0; k < TAG_DEPTH; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= gnt_vld;
      tag_id[0]  <= gnt_id;
      for (int k = 1; k < TAG_DEPTH; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      osc_valid_out   <= '0;
      viz_valid_out   <= 1'b0;
      debug_valid_out <= 1'b0;
      if (tag_vld[TAG_DEPTH-1]) begin
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          if (tag_id[TAG_DEPTH-1] == ID_W'(i)) begin
            osc_data_out[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= bram_data_in;
            osc_valid_out[i] <= 1'b1;
          end
        end
        if (tag_id[TAG_DEPTH-1] == ID_W'(VIZ_ID)) begin
          viz_data_out  <= bram_data_in;
          viz_valid_out <= 1'b1;
        end
        if (tag_id[TAG_DEPTH-1] == ID_W'(DBG_ID)) begin
          debug_data_out  <= bram_data_in;
          debug_valid_out <= 1'b1;
        end
      end
    end
  end

`ifdef STARVATION_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] viz_wait;
  logic [CNT_W-1:0] dbg_wait;

  assign viz_starved = (viz_wait == CNT_W'(STARVE_LIMIT));
  assign dbg_starved = (dbg_wait == CNT_W'(STARVE_LIMIT));

  // Count cycles viz/debug sit waiting; saturate at the limit, clear when served.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      viz_wait <= '0;
      dbg_wait <= '0;
    end else begin
      if (gnt_vld && gnt_id == ID_W'(VIZ_ID)) viz_wait <= '0;
      else if (active[VIZ_ID] && !viz_starved) viz_wait <= viz_wait + 1'b1;
      if (gnt_vld && gnt_id == ID_W'(DBG_ID)) dbg_wait <= '0;
      else if (active[DBG_ID] && !dbg_starved) dbg_wait <= dbg_wait + 1'b1;
    end
  end
`else
  assign viz_starved = 1'b0;
  assign dbg_starved = 1'b0;
`endif

endmodule

// File: tb/tb_wave_read_arbiter.sv
// Testbench for wave_read_arbiter: directed scenarios plus a randomized run against a transaction model.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// The BRAM model returns addr+0x1000 two cycles after the address is presented.
module tb_wave_read_arbiter;
  localparam int N  = 4;
  localparam int SW = 16;
  localparam int WW = 18;
  localparam int L  = 2;
  localparam int NR = N + 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in;
  logic [WW-1:0]     wave_width_in;
  logic              bram_busy_in;
  logic [N-1:0]      osc_req_in;
  logic [N*WW-1:0]   osc_index_in;
  logic [N*SW-1:0]   osc_data_out;
  logic [N-1:0]      osc_valid_out;
  logic              viz_req_in;
  logic [WW-1:0]     viz_index_in;
  logic [SW-1:0]     viz_data_out;
  logic              viz_valid_out;
  logic              debug_req_in;
  logic [WW-1:0]     debug_index_in;
  logic [SW-1:0]     debug_data_out;
  logic              debug_valid_out;
  logic [WW-1:0]     bram_addr_out;
  logic              bram_en_out;
  logic [SW-1:0]     bram_data_in;

  wave_read_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .wave_width_in(wave_width_in), .bram_busy_in(bram_busy_in),
    .osc_req_in(osc_req_in), .osc_index_in(osc_index_in), .osc_data_out(osc_data_out),
    .osc_valid_out(osc_valid_out), .viz_req_in(viz_req_in), .viz_index_in(viz_index_in),
    .viz_data_out(viz_data_out), .viz_valid_out(viz_valid_out), .debug_req_in(debug_req_in),
    .debug_index_in(debug_index_in), .debug_data_out(debug_data_out),
    .debug_valid_out(debug_valid_out), .bram_addr_out(bram_addr_out), .bram_en_out(bram_en_out),
    .bram_data_in(bram_data_in)
  );

  // BRAM: two register stages, content = address + 0x1000.
  logic [SW-1:0] bram_pipe [L];
  always @(posedge clk_in) begin
    bram_pipe[0] <= bram_addr_out[SW-1:0] + 16'h1000;
    for (int k = 1; k < L; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign bram_data_in = bram_pipe[L-1];

  int vectors = 0;
  int miscompares = 0;

  // Transaction model state.
  typedef struct { int due; int id; logic [WW-1:0] addr; } ret_t;
  ret_t          ret_q [$];
  bit            m_pend [NR];
  logic [WW-1:0] m_held [NR];
  logic [SW-1:0] m_data [NR];
  int            m_ptr = 0;
  int            s = 0;
  bit            exp_en = 1'b0;
  logic [WW-1:0] exp_addr = '0;
  logic [NR-1:0] exp_valid = '0;

  function automatic logic req_of(int i);
    if (i < N) return osc_req_in[i];
    if (i == N) return viz_req_in;
    return debug_req_in;
  endfunction

  function automatic logic [WW-1:0] idx_of(int i);
    if (i < N) return osc_index_in[i*WW +: WW];
    if (i == N) return viz_index_in;
    return debug_index_in;
  endfunction

  function automatic logic [SW-1:0] dut_data(int i);
    if (i < N) return osc_data_out[i*SW +: SW];
    if (i == N) return viz_data_out;
    return debug_data_out;
  endfunction

  function automatic logic [NR-1:0] dut_valid();
    return {debug_valid_out, viz_valid_out, osc_valid_out};
  endfunction

  task automatic set_osc(int i, logic [WW-1:0] idx);
    osc_req_in[i] = 1'b1;
    osc_index_in[i*WW +: WW] = idx;
  endtask

  task automatic clear_reqs();
    osc_req_in = '0;
    viz_req_in = 1'b0;
    debug_req_in = 1'b0;
  endtask

  // Apply the current inputs for one clock, advancing the model; afterwards exp_* describe the outputs.
  task automatic step();
    int g;
    bit nen;
    logic [WW-1:0] eff;
    logic [WW-1:0] naddr;
    g = -1;
    nen = 1'b0;
    naddr = exp_addr;
    if (rst_in) begin
      ret_q.delete();
      m_ptr = 0;
      naddr = '0;
      for (int i = 0; i < NR; i++) begin
        m_pend[i] = 1'b0; m_held[i] = '0; m_data[i] = '0;
      end
    end else begin
      if (!bram_busy_in) begin
        // Service order: oscillators starting at the pointer, then viz, then debug.
        for (int k = 0; k < NR && g < 0; k++) begin
          int c;
          c = (k < N) ? (m_ptr + k) % N : k;
          if (m_pend[c] || req_of(c)) g = c;
        end
      end
      if (g >= 0) begin
        eff = req_of(g) ? idx_of(g) : m_held[g];
        naddr = (eff >= wave_width_in) ? '0 : eff;
        nen = 1'b1;
        ret_q.push_back('{s + 2 + L, g, naddr});
        if (g < N) m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < NR; i++) begin
        if (i == g) m_pend[i] = m_pend[i] && req_of(i);
        else        m_pend[i] = m_pend[i] || req_of(i);
        if (req_of(i)) m_held[i] = idx_of(i);
      end
    end
    @(negedge clk_in);
    s++;
    exp_en = nen;
    exp_addr = naddr;
    exp_valid = '0;
    while (ret_q.size() > 0 && ret_q[0].due == s) begin
      exp_valid[ret_q[0].id] = 1'b1;
      m_data[ret_q[0].id] = ret_q[0].addr[SW-1:0] + 16'h1000;
      void'(ret_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    clear_reqs();
    step();
    step();
    vectors++;
    if (bram_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", bram_en_out); end
    vectors++;
    if (bram_addr_out !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", bram_addr_out); end
    vectors++;
    if (dut_valid() !== '0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dut_valid()); end
    for (int i = 0; i < NR; i++) begin
      vectors++;
      if (dut_data(i) !== '0) begin miscompares++; $display("FAIL reset_data%0d: got %h want 0", i, dut_data(i)); end
    end
    rst_in = 1'b0;
  endtask

  task automatic test_single();
    clear_reqs();
    step();
    set_osc(0, 18'd100);
    step();
    clear_reqs();
    vectors++;
    if (bram_en_out !== 1'b1 || bram_addr_out !== 18'd100) begin
      miscompares++; $display("FAIL single_issue: en=%b addr=%0d want en=1 addr=100", bram_en_out, bram_addr_out);
    end
    for (int k = 2; k <= 6; k++) begin
      step();
      vectors++;
      if (dut_valid() !== ((k == 4) ? 6'b000001 : 6'b000000)) begin
        miscompares++; $display("FAIL single_valid_c%0d: got %b want %b", k, dut_valid(), (k == 4) ? 6'b000001 : 6'b000000);
      end
      if (k == 4) begin
        vectors++;
        if (osc_data_out[SW-1:0] !== 16'h1064) begin
          miscompares++; $display("FAIL single_data: got %h want 1064", osc_data_out[SW-1:0]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int rr_mask  [3]    = '{15, 3, 15};
    int rr_idx   [3][4] = '{'{10, 20, 30, 40}, '{50, 60, 0, 0}, '{70, 80, 90, 100}};
    int rr_order [3][4] = '{'{0, 1, 2, 3}, '{0, 1, 0, 0}, '{2, 3, 0, 1}};
    int rr_n     [3]    = '{4, 2, 4};
    rst_in = 1'b1;
    clear_reqs();
    step();
    rst_in = 1'b0;
    for (int b = 0; b < 3; b++) begin
      int cnt [N];
      for (int i = 0; i < N; i++) begin
        cnt[i] = 0;
        if (((rr_mask[b] >> i) & 1) == 1) set_osc(i, WW'(rr_idx[b][i]));
      end
      step();
      clear_reqs();
      for (int g = 0; g < rr_n[b]; g++) begin
        if (g > 0) step();
        for (int i = 0; i < N; i++) if (osc_valid_out[i]) cnt[i]++;
        vectors++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== WW'(rr_idx[b][rr_order[b][g]])) begin
          miscompares++;
          $display("FAIL rr_b%0d_g%0d: en=%b addr=%0d want en=1 addr=%0d", b, g, bram_en_out, bram_addr_out, rr_idx[b][rr_order[b][g]]);
        end
      end
      for (int d = 0; d < 6; d++) begin
        step();
        for (int i = 0; i < N; i++) if (osc_valid_out[i]) cnt[i]++;
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (cnt[i] != ((rr_mask[b] >> i) & 1)) begin
          miscompares++; $display("FAIL rr_b%0d_pulses%0d: got %0d want %0d", b, i, cnt[i], (rr_mask[b] >> i) & 1);
        end
      end
    end
  endtask

  task automatic test_priority();
    for (int t = 0; t < 30; t++) begin
      clear_reqs();
      set_osc(0, WW'(200 + t));
      if (t == 0) begin
        viz_req_in = 1'b1; viz_index_in = 18'd500;
        debug_req_in = 1'b1; debug_index_in = 18'd600;
      end
      step();
      vectors++;
      if (bram_en_out !== 1'b1 || bram_addr_out !== WW'(200 + t)) begin
        miscompares++; $display("FAIL prio_osc_t%0d: en=%b addr=%0d want en=1 addr=%0d", t, bram_en_out, bram_addr_out, 200 + t);
      end
    end
    clear_reqs();
    step();
    vectors++;
    if (bram_en_out !== 1'b1 || bram_addr_out !== 18'd500) begin
      miscompares++; $display("FAIL prio_viz: en=%b addr=%0d want en=1 addr=500", bram_en_out, bram_addr_out);
    end
    step();
    vectors++;
    if (bram_en_out !== 1'b1 || bram_addr_out !== 18'd600) begin
      miscompares++; $display("FAIL prio_debug: en=%b addr=%0d want en=1 addr=600", bram_en_out, bram_addr_out);
    end
    for (int d = 0; d < 6; d++) step();
  endtask

  task automatic test_busy();
    int p0 = 0;
    int p1 = 0;
    int early = 0;
    int exp_seq [3] = '{9, 11, 12};
    clear_reqs();
    set_osc(0, 18'd7);
    step();
    clear_reqs();
    set_osc(1, 18'd8);
    step();
    clear_reqs();
    bram_busy_in = 1'b1;
    set_osc(2, 18'd9);
    viz_req_in = 1'b1; viz_index_in = 18'd11;
    debug_req_in = 1'b1; debug_index_in = 18'd12;
    for (int t = 0; t < 20; t++) begin
      step();
      clear_reqs();
      if (osc_valid_out[0]) p0++;
      if (osc_valid_out[1]) p1++;
      if (osc_valid_out[2] || viz_valid_out || debug_valid_out) early++;
      vectors++;
      if (bram_en_out !== 1'b0) begin miscompares++; $display("FAIL busy_en_t%0d: got %b want 0", t, bram_en_out); end
    end
    vectors++;
    if (p0 != 1 || p1 != 1 || early != 0) begin
      miscompares++; $display("FAIL busy_inflight: pulses osc0=%0d osc1=%0d others=%0d want 1 1 0", p0, p1, early);
    end
    vectors++;
    if (osc_data_out[0 +: SW] !== 16'h1007 || osc_data_out[SW +: SW] !== 16'h1008) begin
      miscompares++; $display("FAIL busy_data: got %h %h want 1007 1008", osc_data_out[0 +: SW], osc_data_out[SW +: SW]);
    end
    bram_busy_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step();
      vectors++;
      if (bram_en_out !== 1'b1 || bram_addr_out !== WW'(exp_seq[g])) begin
        miscompares++; $display("FAIL busy_release_g%0d: en=%b addr=%0d want en=1 addr=%0d", g, bram_en_out, bram_addr_out, exp_seq[g]);
      end
    end
    for (int d = 0; d < 6; d++) step();
  endtask

  task automatic test_range();
    int r_ww  [5] = '{50, 50, 50, 0, 0};
    int r_idx [5] = '{75, 49, 50, 5, 0};
    int r_exp [5] = '{0, 49, 0, 0, 0};
    for (int r = 0; r < 5; r++) begin
      clear_reqs();
      wave_width_in = WW'(r_ww[r]);
      set_osc(3, WW'(r_idx[r]));
      step();
      vectors++;
      if (bram_en_out !== 1'b1 || bram_addr_out !== WW'(r_exp[r])) begin
        miscompares++; $display("FAIL range_w%0d_i%0d: en=%b addr=%0d want en=1 addr=%0d", r_ww[r], r_idx[r], bram_en_out, bram_addr_out, r_exp[r]);
      end
    end
    clear_reqs();
    wave_width_in = 18'd1000;
    for (int d = 0; d < 6; d++) step();
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    clear_reqs();
    set_osc(3, 18'd33);
    step();
    clear_reqs();
    vectors++;
    if (bram_en_out !== 1'b1 || bram_addr_out !== 18'd33) begin
      miscompares++; $display("FAIL midrst_issue: en=%b addr=%0d want en=1 addr=33", bram_en_out, bram_addr_out);
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    for (int i = 0; i < NR; i++) begin
      vectors++;
      if (dut_data(i) !== '0) begin miscompares++; $display("FAIL midrst_data%0d: got %h want 0", i, dut_data(i)); end
    end
    if (dut_valid() !== '0) seen++;
    for (int d = 0; d < 8; d++) begin
      step();
      if (dut_valid() !== '0) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL midrst_pulses: got %0d cycles with valid want 0", seen); end
  endtask

  task automatic test_random();
    rst_in = 1'b1;
    clear_reqs();
    step();
    rst_in = 1'b0;
    wave_width_in = 18'd200;
    for (int t = 0; t < 800; t++) begin
      rst_in = ($urandom_range(0, 299) == 0);
      bram_busy_in = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) begin
        osc_req_in[i] = ($urandom_range(0, 3) == 0);
        osc_index_in[i*WW +: WW] = WW'($urandom_range(0, 255));
      end
      viz_req_in = ($urandom_range(0, 5) == 0);
      viz_index_in = WW'($urandom_range(0, 255));
      debug_req_in = ($urandom_range(0, 7) == 0);
      debug_index_in = WW'($urandom_range(0, 255));
      step();
      vectors++;
      if (bram_en_out !== exp_en) begin miscompares++; $display("FAIL rand_en_s%0d: got %b want %b", s, bram_en_out, exp_en); end
      if (exp_en) begin
        vectors++;
        if (bram_addr_out !== exp_addr) begin miscompares++; $display("FAIL rand_addr_s%0d: got %0d want %0d", s, bram_addr_out, exp_addr); end
      end
      vectors++;
      if (dut_valid() !== exp_valid) begin miscompares++; $display("FAIL rand_valid_s%0d: got %b want %b", s, dut_valid(), exp_valid); end
      for (int i = 0; i < NR; i++) begin
        vectors++;
        if (dut_data(i) !== m_data[i]) begin miscompares++; $display("FAIL rand_data%0d_s%0d: got %h want %h", i, s, dut_data(i), m_data[i]); end
      end
    end
    rst_in = 1'b0;
    bram_busy_in = 1'b0;
    clear_reqs();
  endtask

  initial begin
    rst_in = 1'b1;
    wave_width_in = 18'd1000;
    bram_busy_in = 1'b0;
    osc_index_in = '0;
    viz_index_in = '0;
    debug_index_in = '0;
    clear_reqs();
    for (int i = 0; i < NR; i++) begin
      m_pend[i] = 1'b0; m_held[i] = '0; m_data[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_busy();
    test_range();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
